// File: rtl/jtag_pkg.sv
// JTAG TAP definitions shared by TAP-aware blocks: 4-bit state encoding and shift-state helper.
package jtag_pkg;

    typedef enum logic [3:0] {
        TapEx2Dr  = 4'h0,
        TapEx1Dr  = 4'h1,
        TapShDr   = 4'h2,
        TapPaDr   = 4'h3,
        TapSelIr  = 4'h4,
        TapUpdDr  = 4'h5,
        TapCapDr  = 4'h6,
        TapSelDr  = 4'h7,
        TapEx2Ir  = 4'h8,
        TapEx1Ir  = 4'h9,
        TapShIr   = 4'hA,
        TapPaIr   = 4'hB,
        TapRti    = 4'hC,
        TapUpdIr  = 4'hD,
        TapCapIr  = 4'hE,
        TapTlr    = 4'hF
    } tap_state_e;

    // True when TDO carries shifted data in this state.
    function automatic logic tap_is_shift(input logic [3:0] state, input logic with_ir);
        return (state == TapShDr) || (with_ir && (state == TapShIr));
    endfunction

endpackage

// File: rtl/jtag_tap_tracker.sv
// IEEE 1149.1 TAP controller mirror; advances only on qualified TCK rising edges.
module jtag_tap_tracker
    import jtag_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       rise,
    input  logic       tms,
    output logic [3:0] state
);

    tap_state_e r_state;
    tap_state_e w_state_nxt;

    // State register, synchronous reset into Test-Logic-Reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= TapTlr;
        end else if (rise) begin
            r_state <= w_state_nxt;
        end
    end

    // Standard TAP transition table.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            TapTlr:   w_state_nxt = tms ? TapTlr   : TapRti;
            TapRti:   w_state_nxt = tms ? TapSelDr : TapRti;
            TapSelDr: w_state_nxt = tms ? TapSelIr : TapCapDr;
            TapCapDr: w_state_nxt = tms ? TapEx1Dr : TapShDr;
            TapShDr:  w_state_nxt = tms ? TapEx1Dr : TapShDr;
            TapEx1Dr: w_state_nxt = tms ? TapUpdDr : TapPaDr;
            TapPaDr:  w_state_nxt = tms ? TapEx2Dr : TapPaDr;
            TapEx2Dr: w_state_nxt = tms ? TapUpdDr : TapShDr;
            TapUpdDr: w_state_nxt = tms ? TapSelDr : TapRti;
            TapSelIr: w_state_nxt = tms ? TapTlr   : TapCapIr;
            TapCapIr: w_state_nxt = tms ? TapEx1Ir : TapShIr;
            TapShIr:  w_state_nxt = tms ? TapEx1Ir : TapShIr;
            TapEx1Ir: w_state_nxt = tms ? TapUpdIr : TapPaIr;
            TapPaIr:  w_state_nxt = tms ? TapEx2Ir : TapPaIr;
            TapEx2Ir: w_state_nxt = tms ? TapUpdIr : TapShIr;
            TapUpdIr: w_state_nxt = tms ? TapSelDr : TapRti;
            default:  w_state_nxt = TapTlr;
        endcase
    end

    assign state = r_state;

endmodule

// File: rtl/tdo_capture_packer.sv
// Samples TDO during Shift-DR (optionally Shift-IR), packs bits LSB-first into bytes and
// offers them on a valid/ready port. Optional macro TDO_CAPTURE_PARITY_EN adds byte_parity.
module tdo_capture_packer
    import jtag_pkg::*;
#(
    parameter int unsigned CAPTURE_IR = 0,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             capture_en,
    input  logic             tck,
    input  logic             tms,
    input  logic             tdo,
    input  logic             eof_in,
    output logic [7:0]       byte_out,
    output logic [3:0]       byte_nbits,
    output logic             byte_last,
    output logic             byte_valid,
    input  logic             byte_ready,
    output logic             overflow,
    output logic [3:0]       tap_state,
    output logic [CNT_W-1:0] bit_count
`ifdef TDO_CAPTURE_PARITY_EN
    ,
    output logic             byte_parity
`endif
);

    logic             r_tck_q;
    logic             w_rise;
    logic [3:0]       w_state;
    logic [7:0]       r_shift;
    logic [3:0]       r_idx;
    logic [7:0]       w_shift_nxt;
    logic [3:0]       w_idx_nxt;
    logic             w_sample;
    logic             w_emit;
    logic             w_emit_last;
    logic             w_accept;
    logic             w_load;
    logic             r_valid;
    logic [7:0]       r_byte;
    logic [3:0]       r_nbits;
    logic             r_last;
    logic             r_overflow;
    logic [CNT_W-1:0] r_count;

    jtag_tap_tracker u_tap (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rise   (w_rise),
        .tms    (tms),
        .state  (w_state)
    );

    // TCK edge detector; tck is data in the clk_in domain.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_tck_q <= 1'b0;
        end else begin
            r_tck_q <= tck;
        end
    end

    assign w_rise = tck & ~r_tck_q;

    // Sample decision, next shift contents and byte-completion detection.
    always_comb begin
        w_sample    = w_rise & capture_en & tap_is_shift(w_state, CAPTURE_IR != 0);
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
        if (w_sample) begin
            w_shift_nxt[r_idx[2:0]] = tdo;
            w_idx_nxt               = r_idx + 4'd1;
        end
        w_emit      = 1'b0;
        w_emit_last = 1'b0;
        if (w_sample && (w_idx_nxt == 4'd8)) begin
            w_emit      = 1'b1;
            w_emit_last = tms;
        end else if (w_sample && tms) begin
            w_emit      = 1'b1;
            w_emit_last = 1'b1;
        end else if (eof_in && (w_idx_nxt != 4'd0)) begin
            w_emit      = 1'b1;
            w_emit_last = 1'b1;
        end
        w_accept = r_valid & byte_ready;
        // A new byte only fits if the holding register is empty or draining this cycle.
        w_load   = w_emit & (~r_valid | w_accept);
    end

    // Shift register and bit index; an emitted byte leaves both cleared.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_shift <= 8'h00;
            r_idx   <= 4'd0;
        end else if (w_emit) begin
            r_shift <= 8'h00;
            r_idx   <= 4'd0;
        end else begin
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Output holding register, handshake and sticky overflow.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid    <= 1'b0;
            r_byte     <= 8'h00;
            r_nbits    <= 4'd0;
            r_last     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid <= 1'b1;
                r_byte  <= w_shift_nxt;
                r_nbits <= w_idx_nxt;
                r_last  <= w_emit_last;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
            if (w_emit && !w_load) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Saturating captured-bit counter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_count <= '0;
        end else if (w_sample && !(&r_count)) begin
            r_count <= r_count + 1'b1;
        end
    end

`ifdef TDO_CAPTURE_PARITY_EN
    logic r_parity;

    // Unused upper bits are zero, so a full-byte XOR covers exactly the valid bits.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^w_shift_nxt;
        end
    end

    assign byte_parity = r_parity;
`endif

    assign byte_out   = r_byte;
    assign byte_nbits = r_nbits;
    assign byte_last  = r_last;
    assign byte_valid = r_valid;
    assign overflow   = r_overflow;
    assign tap_state  = w_state;
    assign bit_count  = r_count;

endmodule

// File: tb/tb_tdo_capture_packer.sv
// Bench for tdo_capture_packer: bit-queue reference model checked every cycle, plus directed
// literal expectations along the TAP walk.
module tb_tdo_capture_packer;
    import jtag_pkg::*;

    localparam int unsigned CNT_W = 16;

    logic             clk_in = 1'b0;
    logic             rst_in = 1'b1;
    logic             capture_en = 1'b1;
    logic             tck = 1'b0;
    logic             tms = 1'b0;
    logic             tdo = 1'b0;
    logic             eof_in = 1'b0;
    logic             byte_ready = 1'b1;
    logic [7:0]       byte_out;
    logic [3:0]       byte_nbits;
    logic             byte_last;
    logic             byte_valid;
    logic             overflow;
    logic [3:0]       tap_state;
    logic [CNT_W-1:0] bit_count;
`ifdef TDO_CAPTURE_PARITY_EN
    logic             byte_parity;
`endif

    tdo_capture_packer #(
        .CAPTURE_IR (0),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .capture_en (capture_en),
        .tck        (tck),
        .tms        (tms),
        .tdo        (tdo),
        .eof_in     (eof_in),
        .byte_out   (byte_out),
        .byte_nbits (byte_nbits),
        .byte_last  (byte_last),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .overflow   (overflow),
        .tap_state  (tap_state),
        .bit_count  (bit_count)
`ifdef TDO_CAPTURE_PARITY_EN
        ,
        .byte_parity (byte_parity)
`endif
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: TAP transition tables and a queue of captured bits.
    logic [3:0] nxt0 [16];
    logic [3:0] nxt1 [16];
    logic       m_live = 1'b0;
    logic       m_tck_q;
    logic [3:0] m_tap;
    bit         m_bits[$];
    int         m_count;
    logic       m_valid;
    logic [7:0] m_byte;
    int         m_nbits;
    logic       m_last;
    logic       m_ovf;

    task automatic tr(input tap_state_e s, input tap_state_e n0, input tap_state_e n1);
        nxt0[s] = n0;
        nxt1[s] = n1;
    endtask

    initial begin
        tr(TapTlr,   TapRti,   TapTlr);
        tr(TapRti,   TapRti,   TapSelDr);
        tr(TapSelDr, TapCapDr, TapSelIr);
        tr(TapCapDr, TapShDr,  TapEx1Dr);
        tr(TapShDr,  TapShDr,  TapEx1Dr);
        tr(TapEx1Dr, TapPaDr,  TapUpdDr);
        tr(TapPaDr,  TapPaDr,  TapEx2Dr);
        tr(TapEx2Dr, TapShDr,  TapUpdDr);
        tr(TapUpdDr, TapRti,   TapSelDr);
        tr(TapSelIr, TapCapIr, TapTlr);
        tr(TapCapIr, TapShIr,  TapEx1Ir);
        tr(TapShIr,  TapShIr,  TapEx1Ir);
        tr(TapEx1Ir, TapPaIr,  TapUpdIr);
        tr(TapPaIr,  TapPaIr,  TapEx2Ir);
        tr(TapEx2Ir, TapShIr,  TapUpdIr);
        tr(TapUpdIr, TapRti,   TapSelDr);
    end

    // Model step at each clock edge using the inputs the DUT also sees.
    initial begin
        bit   emit;
        bit   elast;
        bit   acc;
        bit   rise;
        forever begin
            @(posedge clk_in);
            if (rst_in) begin
                m_live  = 1'b1;
                m_tck_q = 1'b0;
                m_tap   = TapTlr;
                m_bits.delete();
                m_count = 0;
                m_valid = 1'b0;
                m_byte  = 8'h00;
                m_nbits = 0;
                m_last  = 1'b0;
                m_ovf   = 1'b0;
            end else begin
                rise    = tck && !m_tck_q;
                m_tck_q = tck;
                acc     = m_valid && byte_ready;
                emit    = 1'b0;
                elast   = 1'b0;
                if (rise) begin
                    if (capture_en && (m_tap == TapShDr)) begin
                        m_bits.push_back(tdo);
                        if (m_count < (1 << CNT_W) - 1) m_count++;
                        if (m_bits.size() == 8) begin
                            emit  = 1'b1;
                            elast = tms;
                        end else if (tms) begin
                            emit  = 1'b1;
                            elast = 1'b1;
                        end
                    end
                    m_tap = tms ? nxt1[m_tap] : nxt0[m_tap];
                end
                if (!emit && eof_in && (m_bits.size() > 0)) begin
                    emit  = 1'b1;
                    elast = 1'b1;
                end
                if (emit) begin
                    logic [7:0] b;
                    b = 8'h00;
                    foreach (m_bits[i]) b[i] = m_bits[i];
                    if (!m_valid || acc) begin
                        m_valid = 1'b1;
                        m_byte  = b;
                        m_nbits = m_bits.size();
                        m_last  = elast;
                    end else begin
                        m_ovf = 1'b1;
                    end
                    m_bits.delete();
                end else if (acc) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk_in) begin
        if (m_live) begin
            chk("tap_state", 32'(tap_state), 32'(m_tap));
            chk("byte_valid", 32'(byte_valid), 32'(m_valid));
            chk("bit_count", 32'(bit_count), 32'(m_count));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            if (m_valid) begin
                chk("byte_out", 32'(byte_out), 32'(m_byte));
                chk("byte_nbits", 32'(byte_nbits), 32'(m_nbits));
                chk("byte_last", 32'(byte_last), 32'(m_last));
`ifdef TDO_CAPTURE_PARITY_EN
                chk("byte_parity", 32'(byte_parity), 32'(^m_byte));
`endif
            end
        end
    end

    // One TCK pulse: high for one clk cycle, then low; returns just after the rising-edge cycle.
    task automatic pulse(input logic ms, input logic d);
        @(posedge clk_in);
        #1;
        tms = ms;
        tdo = d;
        tck = 1'b1;
        @(posedge clk_in);
        #1;
        tck = 1'b0;
    endtask

    task automatic shift_byte(input logic [7:0] b, input logic last_tms);
        for (int i = 0; i < 8; i++) pulse((i == 7) ? last_tms : 1'b0, b[i]);
    endtask

    initial begin
        logic [7:0] pat;
        repeat (3) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        chk("reset tap_state", 32'(tap_state), 32'(TapTlr));
        chk("reset byte_valid", 32'(byte_valid), 32'd0);
        chk("reset bit_count", 32'(bit_count), 32'd0);
        chk("reset byte_out", 32'(byte_out), 32'd0);

        // Walk to Shift-DR.
        for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b0);
        chk("enter tap_state", 32'(tap_state), 32'(TapShDr));
        chk("enter byte_valid", 32'(byte_valid), 32'd0);
        chk("enter bit_count", 32'(bit_count), 32'd0);

        // Full byte 1,0,1,1,0,0,1,0 exiting on the 8th edge.
        pat = 8'b0100_1101;
        shift_byte(pat, 1'b1);
        chk("full byte_valid", 32'(byte_valid), 32'd1);
        chk("full byte_out", 32'(byte_out), 32'h4D);
        chk("full byte_nbits", 32'(byte_nbits), 32'd8);
        chk("full byte_last", 32'(byte_last), 32'd1);
        chk("full bit_count", 32'(bit_count), 32'd8);

        // Exit1 -> Pause -> Exit2 -> Shift-DR, then 3 bits 1,1,0 with exit.
        pulse(1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        chk("partial byte_out", 32'(byte_out), 32'h03);
        chk("partial byte_nbits", 32'(byte_nbits), 32'd3);
        chk("partial byte_last", 32'(byte_last), 32'd1);
        chk("partial bit_count", 32'(bit_count), 32'd11);

        // Back to Shift-DR; two full bytes with the consumer stalled.
        pulse(1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);
        byte_ready = 1'b0;
        pat = 8'hA5;
        shift_byte(pat, 1'b0);
        pat = 8'h3C;
        shift_byte(pat, 1'b0);
        chk("ovf byte_valid", 32'(byte_valid), 32'd1);
        chk("ovf held byte_out", 32'(byte_out), 32'hA5);
        chk("ovf byte_last", 32'(byte_last), 32'd0);
        chk("ovf overflow", 32'(overflow), 32'd1);
        @(posedge clk_in);
        #1;
        byte_ready = 1'b1;
        @(posedge clk_in);
        #1;
        chk("ovf drained byte_valid", 32'(byte_valid), 32'd0);

        // Five bits 1,0,0,1,1 then an eof flush.
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        chk("pre-eof byte_valid", 32'(byte_valid), 32'd0);
        @(posedge clk_in);
        #1;
        eof_in = 1'b1;
        @(posedge clk_in);
        #1;
        eof_in = 1'b0;
        chk("eof byte_valid", 32'(byte_valid), 32'd1);
        chk("eof byte_out", 32'(byte_out), 32'h19);
        chk("eof byte_nbits", 32'(byte_nbits), 32'd5);
        chk("eof byte_last", 32'(byte_last), 32'd1);
        chk("eof bit_count", 32'(bit_count), 32'd32);
        @(posedge clk_in);
        #1;
        eof_in = 1'b1;
        @(posedge clk_in);
        #1;
        eof_in = 1'b0;
        chk("empty eof byte_valid", 32'(byte_valid), 32'd0);

        // Leave Shift-DR with capture disabled, walk to Shift-IR and shift 8 bits.
        capture_en = 1'b0;
        pulse(1'b1, 1'b1);
        chk("disabled exit byte_valid", 32'(byte_valid), 32'd0);
        capture_en = 1'b1;
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b0);
        pulse(1'b0, 1'b0);
        pat = 8'hFF;
        shift_byte(pat, 1'b0);
        chk("ir tap_state", 32'(tap_state), 32'(TapShIr));
        chk("ir byte_valid", 32'(byte_valid), 32'd0);
        chk("ir bit_count", 32'(bit_count), 32'd32);

        // Reset clears sticky overflow and counters.
        @(posedge clk_in);
        #1;
        rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        rst_in = 1'b0;
        chk("rst tap_state", 32'(tap_state), 32'(TapTlr));
        chk("rst overflow", 32'(overflow), 32'd0);
        chk("rst bit_count", 32'(bit_count), 32'd0);
        repeat (3) @(posedge clk_in);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
